// File: rtl/simd_pkg.sv
// Shared SIMD definitions: element-width codes, their decoding, and the
// partial-product matrix shape consumed by the pmul reduction tree.
package simd_pkg;

  typedef logic [1:0] sew_t;

  localparam sew_t SEW_8  = 2'd0;
  localparam sew_t SEW_16 = 2'd1;
  localparam sew_t SEW_32 = 2'd2;
  localparam sew_t SEW_64 = 2'd3;

  localparam int unsigned PMUL_VECTOR_WIDTH = 64;

  // Row index is the multiplier bit, column index the multiplicand bit.
  typedef logic [PMUL_VECTOR_WIDTH-1:0][PMUL_VECTOR_WIDTH-1:0] pp_matrix_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } skid_state_t;

  function automatic int unsigned sew_bits(input sew_t code);
    return 32'd8 << code;
  endfunction

  function automatic sew_t clamp_sew(input sew_t code, input sew_t max_code);
    return (code > max_code) ? max_code : code;
  endfunction

endpackage

// File: rtl/pp_lane_mask.sv
// Bit-level partial-product matrix with every cross-lane product forced to 0.
// Purely combinational; the per-entry lane-membership table is fixed at elaboration.
module pp_lane_mask
  import simd_pkg::*;
#(
  parameter int unsigned VECTOR_WIDTH = 64
) (
  input  logic [VECTOR_WIDTH-1:0]                   i_a,
  input  logic [VECTOR_WIDTH-1:0]                   i_b,
  input  sew_t                                      i_sew,
  output logic [VECTOR_WIDTH-1:0][VECTOR_WIDTH-1:0] o_matrix
);

  for (genvar gr = 0; gr < VECTOR_WIDTH; gr++) begin : g_row
    for (genvar gc = 0; gc < VECTOR_WIDTH; gc++) begin : g_col
      // Bit k set when row and column fall in the same lane for E = 8 << k.
      localparam logic [3:0] KEEP = {(gr / 64) == (gc / 64),
                                     (gr / 32) == (gc / 32),
                                     (gr / 16) == (gc / 16),
                                     (gr / 8)  == (gc / 8)};
      assign o_matrix[gr][gc] = i_b[gr] & i_a[gc] & KEEP[i_sew];
    end
  end

endmodule

// File: rtl/pmul_ppgen.sv
// Registered partial-product generator: lane-masked matrix behind a two-entry
// skid buffer so downstream backpressure never reaches in_ready combinationally.
module pmul_ppgen
  import simd_pkg::*;
#(
  parameter int unsigned VECTOR_WIDTH = 64
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [VECTOR_WIDTH-1:0]                   in_a,
  input  logic [VECTOR_WIDTH-1:0]                   in_b,
  input  logic [1:0]                                in_sew,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [VECTOR_WIDTH-1:0][VECTOR_WIDTH-1:0] matrix_out,
  output logic [1:0]                                out_sew
);

  typedef logic [VECTOR_WIDTH-1:0][VECTOR_WIDTH-1:0] matrix_t;

  // Largest code whose element still fits in the vector.
  localparam sew_t MAX_SEW = (VECTOR_WIDTH >= 64) ? SEW_64
                                                  : sew_t'($clog2(VECTOR_WIDTH) - 3);

  sew_t        w_sew;
  matrix_t     w_pp;
  skid_state_t r_state;
  skid_state_t w_state_next;
  matrix_t     r_main_mat;
  matrix_t     r_skid_mat;
  sew_t        r_main_sew;
  sew_t        r_skid_sew;
  logic        w_main_valid;
  logic        w_skid_valid;
  logic        w_accept;
  logic        w_drain;

  assign w_sew = clamp_sew(in_sew, MAX_SEW);

  pp_lane_mask #(
    .VECTOR_WIDTH(VECTOR_WIDTH)
  ) u_mask (
    .i_a     (in_a),
    .i_b     (in_b),
    .i_sew   (w_sew),
    .o_matrix(w_pp)
  );

  assign w_main_valid = (r_state != BUF_EMPTY);
  assign w_skid_valid = (r_state == BUF_FULL);
  assign in_ready     = !w_skid_valid;
  assign out_valid    = w_main_valid;
  assign matrix_out   = r_main_mat;
  assign out_sew      = r_main_sew;
  assign w_accept     = in_valid && in_ready;
  assign w_drain      = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BUF_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the default assignment comes first so every path drives the output and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BUF_EMPTY: if (w_accept) w_state_next = BUF_ONE;
      BUF_ONE: begin
        if (w_accept && !w_drain)      w_state_next = BUF_FULL;
        else if (!w_accept && w_drain) w_state_next = BUF_EMPTY;
      end
      BUF_FULL:  if (w_drain) w_state_next = BUF_ONE;
      default:   w_state_next = BUF_EMPTY;
    endcase
  end

  // NOTE: payload registers carry no reset; only the occupancy state is cleared, which qualifies them.
  always_ff @(posedge clk) begin
    if (w_skid_valid && w_drain) begin
      r_main_mat <= r_skid_mat;
      r_main_sew <= r_skid_sew;
    end else if (w_accept && (!w_main_valid || w_drain)) begin
      r_main_mat <= w_pp;
      r_main_sew <= w_sew;
    end
    if (w_accept && w_main_valid && !w_drain) begin
      r_skid_mat <= w_pp;
      r_skid_sew <= w_sew;
    end
  end

endmodule

// File: tb/tb_pmul_ppgen.sv
// Directed bench for pmul_ppgen: lane masking, lane products after reduction,
// skid-buffer backpressure, streaming and reset while full.
module tb_pmul_ppgen;
  import simd_pkg::*;

  localparam int unsigned VW = 64;
  typedef logic [VW-1:0][VW-1:0] mat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_a;
  logic [VW-1:0] in_b;
  logic [1:0]    in_sew;
  logic          out_valid;
  logic          out_ready;
  mat_t          matrix_out;
  logic [1:0]    out_sew;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pmul_ppgen #(.VECTOR_WIDTH(VW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sew    (in_sew),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .matrix_out(matrix_out),
    .out_sew   (out_sew)
  );

  // Reference: keep b[i]&a[j] only when row and column share a lane.
  function automatic mat_t model(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                 input logic [1:0] sew);
    mat_t m;
    int   e;
    m = '0;
    e = 8 << sew;
    for (int i = 0; i < VW; i++)
      for (int j = 0; j < VW; j++)
        if ((i / e) == (j / e)) m[i][j] = b[i] & a[j];
    return m;
  endfunction

  // Weighted sum of one diagonal lane block, i.e. what the pmul chain reduces it to.
  function automatic logic [127:0] lane_product(input mat_t m, input int e, input int lane);
    logic [127:0] p;
    int           base;
    p    = '0;
    base = lane * e;
    for (int i = 0; i < e; i++)
      for (int j = 0; j < e; j++)
        if (m[base+i][base+j] == 1'b1) p = p + (128'd1 << (i + j));
    return p;
  endfunction

  function automatic void report_matrix(input string name, input mat_t got, input mat_t exp);
    for (int i = 0; i < VW; i++) begin
      if (got[i] !== exp[i]) begin
        $display("FAIL %s: row %0d got %h expected %h", name, i, got[i], exp[i]);
        return;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [VW-1:0] a, input logic [VW-1:0] b,
                       input logic [1:0] s);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_sew   = s;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, SEW_8);
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    drive(1'b0, '0, '0, SEW_8);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_beat_dropped: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_single_e8();
    mat_t exp;
    int   offdiag;
    out_ready = 1'b1;
    drive(1'b1, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0003, SEW_8);
    exp = model(in_a, in_b, SEW_8);
    tick();
    drive(1'b0, '0, '0, SEW_8);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL e8_latency: out_valid got %b expected 1", out_valid);
    end
    checks++;
    if (matrix_out !== exp) begin
      errors++;
      report_matrix("e8_matrix", matrix_out, exp);
    end
    offdiag = 0;
    for (int i = 0; i < VW; i++)
      for (int j = 0; j < VW; j++)
        if ((i / 8) != (j / 8) && matrix_out[i][j] !== 1'b0) offdiag++;
    checks++;
    if (offdiag != 0) begin
      errors++;
      $display("FAIL e8_offdiag: %0d nonzero cross-lane bits expected 0", offdiag);
    end
    checks++;
    if (lane_product(matrix_out, 8, 0) !== 128'h02FD) begin
      errors++;
      $display("FAIL e8_lane0_product: got %h expected 02fd", lane_product(matrix_out, 8, 0));
    end
    checks++;
    if (out_sew !== SEW_8) begin
      errors++;
      $display("FAIL e8_out_sew: got %0d expected 0", out_sew);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL e8_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_e64();
    out_ready = 1'b1;
    drive(1'b1, {VW{1'b1}}, {VW{1'b1}}, SEW_64);
    tick();
    drive(1'b0, '0, '0, SEW_8);
    checks++;
    if (matrix_out !== {(VW*VW){1'b1}}) begin
      errors++;
      report_matrix("e64_all_ones", matrix_out, {(VW*VW){1'b1}});
    end
    checks++;
    if (lane_product(matrix_out, 64, 0) !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin
      errors++;
      $display("FAIL e64_product: got %h expected fffffffffffffffe0000000000000001",
               lane_product(matrix_out, 64, 0));
    end
    checks++;
    if (out_sew !== SEW_64) begin
      errors++;
      $display("FAIL e64_out_sew: got %0d expected 3", out_sew);
    end
    tick();
  endtask

  task automatic test_backpressure();
    mat_t ea, eb, ec;
    logic [VW-1:0] aa, ab, ac, ba, bb, bc;
    aa = 64'h0123_4567_89AB_CDEF; ba = 64'hFEDC_BA98_7654_3210;
    ab = 64'hDEAD_BEEF_CAFE_F00D; bb = 64'h0F0F_F0F0_1234_8765;
    ac = 64'hA5A5_5A5A_FFFF_0001; bc = 64'h8000_0001_7FFF_FFFE;
    ea = model(aa, ba, SEW_8);
    eb = model(ab, bb, SEW_16);
    ec = model(ac, bc, SEW_32);
    out_ready = 1'b0;
    drive(1'b1, aa, ba, SEW_8);
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || matrix_out !== ea) begin
      errors++;
      $display("FAIL bp_A_loaded: in_ready %b out_valid %b expected 1 1", in_ready, out_valid);
      report_matrix("bp_A_loaded", matrix_out, ea);
    end
    drive(1'b1, ab, bb, SEW_16);
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_low_after_B: got %b expected 0", in_ready);
    end
    drive(1'b1, ac, bc, SEW_32);
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || matrix_out !== ea || out_sew !== SEW_8) begin
        errors++;
        $display("FAIL bp_A_stable: cycle %0d in_ready %b out_sew %0d expected 0 0",
                 k, in_ready, out_sew);
        report_matrix("bp_A_stable", matrix_out, ea);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || matrix_out !== eb || out_sew !== SEW_16 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_B_out: out_valid %b out_sew %0d in_ready %b expected 1 1 1",
               out_valid, out_sew, in_ready);
      report_matrix("bp_B_out", matrix_out, eb);
    end
    tick();
    drive(1'b0, '0, '0, SEW_8);
    checks++;
    if (out_valid !== 1'b1 || matrix_out !== ec || out_sew !== SEW_32) begin
      errors++;
      $display("FAIL bp_C_out: out_valid %b out_sew %0d expected 1 2", out_valid, out_sew);
      report_matrix("bp_C_out", matrix_out, ec);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] a, b;
    logic [1:0]    s;
    mat_t          exp;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      s = 2'($urandom_range(3, 0));
      exp = model(a, b, s);
      drive(1'b1, a, b, s);
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_sew !== s || matrix_out !== exp) begin
        errors++;
        $display("FAIL stream_beat%0d: out_valid %b in_ready %b out_sew %0d expected 1 1 %0d",
                 k, out_valid, in_ready, out_sew, s);
        report_matrix("stream_beat", matrix_out, exp);
      end
    end
    drive(1'b0, '0, '0, SEW_8);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    mat_t eg;
    out_ready = 1'b0;
    drive(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, SEW_16);
    tick();
    drive(1'b1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, SEW_32);
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_full: in_ready got %b expected 0", in_ready);
    end
    rst = 1'b1;
    drive(1'b1, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, SEW_8);
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_cleared: out_valid %b in_ready %b expected 0 1", out_valid, in_ready);
    end
    drive(1'b0, '0, '0, SEW_8);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_no_stale: cycle %0d out_valid got %b expected 0", k, out_valid);
      end
    end
    eg = model(64'h00FF_00FF_00FF_00FF, 64'hFFFF_0000_FFFF_0000, SEW_16);
    drive(1'b1, 64'h00FF_00FF_00FF_00FF, 64'hFFFF_0000_FFFF_0000, SEW_16);
    tick();
    drive(1'b0, '0, '0, SEW_8);
    checks++;
    if (out_valid !== 1'b1 || out_sew !== SEW_16 || matrix_out !== eg) begin
      errors++;
      $display("FAIL rstmid_fresh: out_valid %b out_sew %0d expected 1 1", out_valid, out_sew);
      report_matrix("rstmid_fresh", matrix_out, eg);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_e8();
    test_e64();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
